// File: rtl/uart_rx_ctrl_pkg.sv
// uart_rx_ctrl_pkg: shared parity codes, FSM states and config layout for the UART Rx controller
package uart_rx_ctrl_pkg;
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;
  typedef enum logic [1:0] {ST_OFF = 2'b00, ST_IDLE = 2'b01, ST_FRAME = 2'b10} state_e;
  typedef struct packed {
    logic       rx_en;
    logic       stopbit;
    logic [1:0] parity;
  } cfg_t;
endpackage

// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: config, Rx-core, read-side and interrupt signals of the UART Rx controller
interface uart_rx_ctrl_if #(parameter int AW = 3);
  logic          cfg_wr_en;
  logic [3:0]    cfg_wdata;
  logic [AW:0]   cfg_thresh;
  logic          baud_tick;
  logic          rx_line;
  logic [7:0]    UART_Rx_data_payload;
  logic          UART_ctrl_FIFO_w_en;
  logic          FIFO_ctrl_full;
  logic          Cfg_ctrl_Rx_en;
  logic          Cfg_ctrl_stopbit;
  logic [1:0]    Cfg_ctrl_paritybit;
  logic          rd_en;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic [AW:0]   level;
  logic          irq_thresh;
  logic          irq_timeout;
  logic          ovr_err;
  logic          frm_err;
  logic          err_clr;
  modport master (
    output cfg_wr_en, cfg_wdata, cfg_thresh, baud_tick, rx_line, UART_Rx_data_payload,
           UART_ctrl_FIFO_w_en, rd_en, err_clr,
    input  FIFO_ctrl_full, Cfg_ctrl_Rx_en, Cfg_ctrl_stopbit, Cfg_ctrl_paritybit, rd_data,
           rd_valid, level, irq_thresh, irq_timeout, ovr_err, frm_err
  );
  modport slave (
    input  cfg_wr_en, cfg_wdata, cfg_thresh, baud_tick, rx_line, UART_Rx_data_payload,
           UART_ctrl_FIFO_w_en, rd_en, err_clr,
    output FIFO_ctrl_full, Cfg_ctrl_Rx_en, Cfg_ctrl_stopbit, Cfg_ctrl_paritybit, rd_data,
           rd_valid, level, irq_thresh, irq_timeout, ovr_err, frm_err
  );
endinterface

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: first-word-fall-through FIFO with registered level/full and overflow pulse
module uart_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic [AW:0]  level,
  output logic         full,
  output logic         empty,
  output logic         ovf
);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] lvl_q;
  logic push_ok, pop_ok;
  assign full    = lvl_q == (AW+1)'(DEPTH);
  assign empty   = lvl_q == '0;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign ovf     = push && full;
  assign rdata   = empty ? '0 : mem_q[rp_q];
  assign level   = lvl_q;
  // storage array needs no reset; empty masks stale contents
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wp_q] <= wdata;
  end
  // pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      lvl_q <= '0;
    end else begin
      wp_q  <= wp_q + AW'(push_ok);
      rp_q  <= rp_q + AW'(pop_ok);
      lvl_q <= lvl_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: Rx config sequencing, frame watchdog, receive FIFO and interrupt generation
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int AW        = 3,
  parameter int TO_TICKS  = 32,
  parameter int FRAME_MAX = 48
) (
  input logic           glb_clk,
  input logic           glb_rstn,
  uart_rx_ctrl_if.slave bus
);
  state_e state_q, state_d;
  cfg_t shadow_q, shadow_d, applied_q, applied_d;
  logic pend_q, pend_d, ovr_q, ovr_d, frm_q, frm_d;
  logic [7:0] fcnt_q, fcnt_d, tcnt_q, tcnt_d;
  logic apply, wdog, fifo_full, fifo_empty, fifo_ovf, push_ok, pop_ok;
  logic [AW:0] level;
  uart_sync_fifo #(.DEPTH(DEPTH), .AW(AW), .W(8)) u_fifo (
    .clk  (glb_clk),
    .rst_n(glb_rstn),
    .push (bus.UART_ctrl_FIFO_w_en),
    .pop  (bus.rd_en),
    .wdata(bus.UART_Rx_data_payload),
    .rdata(bus.rd_data),
    .level(level),
    .full (fifo_full),
    .empty(fifo_empty),
    .ovf  (fifo_ovf)
  );
  assign push_ok                = bus.UART_ctrl_FIFO_w_en && !fifo_full;
  assign pop_ok                 = bus.rd_en && !fifo_empty;
  assign bus.level              = level;
  assign bus.rd_valid           = !fifo_empty;
  assign bus.FIFO_ctrl_full     = fifo_full;
  assign bus.Cfg_ctrl_Rx_en     = applied_q.rx_en;
  assign bus.Cfg_ctrl_stopbit   = applied_q.stopbit;
  assign bus.Cfg_ctrl_paritybit = applied_q.parity;
  assign bus.irq_thresh         = bus.cfg_thresh != '0 && level >= bus.cfg_thresh;
  assign bus.irq_timeout        = tcnt_q == 8'(TO_TICKS);
  assign bus.ovr_err            = ovr_q;
  assign bus.frm_err            = frm_q;
  // config is applied only outside a frame; a received byte beats the watchdog
  always_comb begin
    apply     = pend_q && state_q != ST_FRAME;
    wdog      = state_q == ST_FRAME && !bus.UART_ctrl_FIFO_w_en && fcnt_q == 8'(FRAME_MAX);
    state_d   = state_q == ST_OFF  ? (apply && shadow_q.rx_en ? ST_IDLE : ST_OFF)
              : state_q == ST_IDLE ? (apply && !shadow_q.rx_en ? ST_OFF : !bus.rx_line ? ST_FRAME : ST_IDLE)
              : state_q == ST_FRAME ? (bus.UART_ctrl_FIFO_w_en || wdog ? ST_IDLE : ST_FRAME)
              : ST_OFF;
    fcnt_d    = state_q == ST_FRAME ? fcnt_q + 8'(bus.baud_tick) : '0;
    tcnt_d    = (push_ok || pop_ok || level == '0) ? '0
              : (bus.baud_tick && state_q != ST_FRAME && tcnt_q != 8'(TO_TICKS)) ? tcnt_q + 8'd1
              : tcnt_q;
    pend_d    = bus.cfg_wr_en || (pend_q && !apply);
    shadow_d  = bus.cfg_wr_en ? cfg_t'(bus.cfg_wdata) : shadow_q;
    applied_d = apply ? shadow_q : applied_q;
    ovr_d     = fifo_ovf || (ovr_q && !bus.err_clr);
    frm_d     = wdog || (frm_q && !bus.err_clr);
  end
  // state and config registers
  always_ff @(posedge glb_clk or negedge glb_rstn) begin
    if (!glb_rstn) begin
      state_q   <= ST_OFF;
      shadow_q  <= '0;
      applied_q <= '0;
      pend_q    <= 1'b0;
      fcnt_q    <= '0;
      tcnt_q    <= '0;
      ovr_q     <= 1'b0;
      frm_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      applied_q <= applied_d;
      pend_q    <= pend_d;
      fcnt_q    <= fcnt_d;
      tcnt_q    <= tcnt_d;
      ovr_q     <= ovr_d;
      frm_q     <= frm_d;
    end
  end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed and randomized check of uart_rx_ctrl against a queue-based model
module tb_uart_rx_ctrl;
  localparam int DEPTH = 8, AW = 3, TO_TICKS = 32, FRAME_MAX = 48;
  logic glb_clk = 1'b0, glb_rstn = 1'b0;
  int total = 0, bad = 0;
  uart_rx_ctrl_if #(.AW(AW)) bus ();
  uart_rx_ctrl #(.DEPTH(DEPTH), .AW(AW), .TO_TICKS(TO_TICKS), .FRAME_MAX(FRAME_MAX)) dut (
    .glb_clk (glb_clk),
    .glb_rstn(glb_rstn),
    .bus     (bus)
  );
  always #5 glb_clk = ~glb_clk;

  logic [7:0] mq[$];
  int ms = 0, mf = 0, mt = 0;
  bit m_pend = 0, m_ovr = 0, m_frm = 0;
  logic [3:0] m_sh = '0, m_cfg = '0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // model: 0=receiver off, 1=waiting for start, 2=inside a frame
  always @(posedge glb_clk) begin
    bit full, empty, wok, rok, apl, w;
    int n, nms;
    if (!glb_rstn) begin
      mq.delete(); ms = 0; mf = 0; mt = 0;
      m_pend = 0; m_ovr = 0; m_frm = 0; m_sh = '0; m_cfg = '0;
    end else begin
      n = mq.size();
      w = bus.UART_ctrl_FIFO_w_en;
      full = n == DEPTH; empty = n == 0;
      wok = w && !full; rok = bus.rd_en && !empty;
      apl = m_pend && ms != 2;
      nms = ms;
      if (ms == 0 && apl && m_sh[3]) nms = 1;
      if (ms == 1) nms = (apl && !m_sh[3]) ? 0 : (!bus.rx_line ? 2 : 1);
      if (ms == 2 && w) nms = 1;
      else if (ms == 2 && mf == FRAME_MAX) begin nms = 1; m_frm = 1; end
      else if (bus.err_clr) m_frm = 0;
      if (ms == 2 && nms == 2) mf += int'(bus.baud_tick); else mf = 0;
      if (wok || rok || n == 0) mt = 0;
      else if (bus.baud_tick && ms != 2 && mt < TO_TICKS) mt++;
      if (w && full) m_ovr = 1; else if (bus.err_clr) m_ovr = 0;
      if (apl) m_cfg = m_sh;
      m_pend = bus.cfg_wr_en || (m_pend && !apl);
      if (bus.cfg_wr_en) m_sh = bus.cfg_wdata;
      if (rok) void'(mq.pop_front());
      if (wok) mq.push_back(bus.UART_Rx_data_payload);
      ms = nms;
    end
  end

  // every cycle out of reset, outputs must match the model
  always @(negedge glb_clk) begin
    if (glb_rstn) begin
      chk("rd_valid", int'(bus.rd_valid), int'(mq.size() != 0));
      chk("rd_data", int'(bus.rd_data), mq.size() != 0 ? int'(mq[0]) : 0);
      chk("level", int'(bus.level), mq.size());
      chk("full", int'(bus.FIFO_ctrl_full), int'(mq.size() == DEPTH));
      chk("cfg", int'({bus.Cfg_ctrl_Rx_en, bus.Cfg_ctrl_stopbit, bus.Cfg_ctrl_paritybit}), int'(m_cfg));
      chk("irq_thresh", int'(bus.irq_thresh), int'(bus.cfg_thresh != 0 && mq.size() >= int'(bus.cfg_thresh)));
      chk("irq_timeout", int'(bus.irq_timeout), int'(mt == TO_TICKS));
      chk("ovr_err", int'(bus.ovr_err), int'(m_ovr));
      chk("frm_err", int'(bus.frm_err), int'(m_frm));
    end
  end

  task automatic clk1();
    @(posedge glb_clk);
    #2;
    bus.cfg_wr_en = 0; bus.UART_ctrl_FIFO_w_en = 0; bus.rd_en = 0;
    bus.err_clr = 0; bus.baud_tick = 0;
  endtask

  task automatic wr_byte(input logic [7:0] b);
    bus.UART_Rx_data_payload = b; bus.UART_ctrl_FIFO_w_en = 1; clk1();
  endtask

  task automatic cfg_wr(input logic [3:0] v);
    bus.cfg_wdata = v; bus.cfg_wr_en = 1; clk1();
  endtask

  int wr_tab[8] = '{25, 60, 0, 10, 40, 0, 15, 35};
  int rd_tab[8] = '{25, 10, 30, 50, 40, 5, 60, 20};

  initial begin
    int wr_pct, rd_pct;
    bus.cfg_wr_en = 0; bus.cfg_wdata = '0; bus.cfg_thresh = '0; bus.baud_tick = 0;
    bus.rx_line = 1; bus.UART_Rx_data_payload = '0; bus.UART_ctrl_FIFO_w_en = 0;
    bus.rd_en = 0; bus.err_clr = 0;
    repeat (3) clk1();
    glb_rstn = 1;
    chk("rst_level", int'(bus.level), 0);
    chk("rst_valid", int'(bus.rd_valid), 0);
    chk("rst_data", int'(bus.rd_data), 0);
    chk("rst_full", int'(bus.FIFO_ctrl_full), 0);
    chk("rst_cfg", int'({bus.Cfg_ctrl_Rx_en, bus.Cfg_ctrl_stopbit, bus.Cfg_ctrl_paritybit}), 0);
    chk("rst_err", int'({bus.irq_timeout, bus.ovr_err, bus.frm_err}), 0);
    cfg_wr(4'b1010);
    chk("cfg_pending", int'(bus.Cfg_ctrl_Rx_en), 0);
    clk1();
    chk("cfg_rx_en", int'(bus.Cfg_ctrl_Rx_en), 1);
    chk("cfg_stop", int'(bus.Cfg_ctrl_stopbit), 0);
    chk("cfg_par", int'(bus.Cfg_ctrl_paritybit), 2);
    bus.rx_line = 0; clk1(); bus.rx_line = 1;
    cfg_wr(4'b0000);
    clk1(); clk1();
    chk("cfg_deferred", int'(bus.Cfg_ctrl_Rx_en), 1);
    wr_byte(8'hA5);
    chk("cfg_after_wen", int'(bus.Cfg_ctrl_Rx_en), 1);
    clk1();
    chk("cfg_off", int'(bus.Cfg_ctrl_Rx_en), 0);
    chk("head_a5", int'(bus.rd_data), 8'hA5);
    bus.rd_en = 1; clk1();
    chk("drained", int'(bus.level), 0);
    for (int i = 1; i <= 8; i++) wr_byte(8'(i));
    chk("fill_level", int'(bus.level), 8);
    chk("fill_full", int'(bus.FIFO_ctrl_full), 1);
    wr_byte(8'hFF);
    chk("ovr_set", int'(bus.ovr_err), 1);
    chk("ovr_level", int'(bus.level), 8);
    for (int i = 1; i <= 8; i++) begin
      chk("read_order", int'(bus.rd_data), i);
      bus.rd_en = 1; clk1();
    end
    chk("read_empty", int'(bus.rd_valid), 0);
    wr_byte(8'h33);
    repeat (TO_TICKS - 1) begin bus.baud_tick = 1; clk1(); end
    chk("to_before", int'(bus.irq_timeout), 0);
    bus.baud_tick = 1; clk1();
    chk("to_fire", int'(bus.irq_timeout), 1);
    bus.rd_en = 1; clk1();
    chk("to_clear", int'(bus.irq_timeout), 0);
    chk("to_level", int'(bus.level), 0);
    bus.err_clr = 1; clk1();
    chk("ovr_clr", int'(bus.ovr_err), 0);
    cfg_wr(4'b1010); clk1();
    bus.rx_line = 0; clk1(); bus.rx_line = 1;
    repeat (FRAME_MAX) begin bus.baud_tick = 1; clk1(); end
    chk("wdog_before", int'(bus.frm_err), 0);
    clk1();
    chk("wdog_fire", int'(bus.frm_err), 1);
    bus.err_clr = 1; clk1();
    chk("frm_clr", int'(bus.frm_err), 0);
    cfg_wr(4'b0101); clk1();
    chk("idle_apply", int'({bus.Cfg_ctrl_Rx_en, bus.Cfg_ctrl_stopbit, bus.Cfg_ctrl_paritybit}), 5);
    bus.cfg_thresh = 4;
    repeat (3) wr_byte(8'h10);
    chk("thr_below", int'(bus.irq_thresh), 0);
    wr_byte(8'h11);
    chk("thr_at", int'(bus.irq_thresh), 1);
    bus.rd_en = 1; wr_byte(8'h77);
    chk("thr_rw_level", int'(bus.level), 4);
    chk("thr_rw_irq", int'(bus.irq_thresh), 1);
    for (int c = 0; c < 4000; c++) begin
      wr_pct = wr_tab[(c / 500) % 8];
      rd_pct = rd_tab[(c / 500) % 8];
      if ($urandom_range(999) == 0) begin
        glb_rstn = 0; clk1(); glb_rstn = 1;
      end
      bus.cfg_wr_en = $urandom_range(99) < 4;
      bus.cfg_wdata = 4'($urandom);
      if ($urandom_range(99) < 2) bus.cfg_thresh = 4'($urandom_range(8));
      bus.baud_tick = $urandom_range(99) < 30;
      bus.rx_line = $urandom_range(99) >= 8;
      bus.UART_Rx_data_payload = 8'($urandom);
      bus.UART_ctrl_FIFO_w_en = $urandom_range(99) < wr_pct;
      bus.rd_en = $urandom_range(99) < rd_pct;
      bus.err_clr = $urandom_range(99) < 3;
      clk1();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
